inst_fetch_sequencer: RTL

- Sits directly downstream of the instruction memory wrapper: reads the currently loaded instruction block word-by-word and streams it to the decoder over a valid/ready interface.
- Returns each drained block with a one-cycle `imem_rd_block_done` pulse.
- Prefetches the next block by toggling `decoder_ld_req_in` with the next DDR address and size.
- Block 0 is loaded by the host (slave path); this block then sequences through `num_blocks` blocks.

---
 rtl/inst_fetch_sequencer.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/inst_fetch_sequencer.sv
// Streams imem instruction blocks word-by-word to the decoder and prefetches the next block from DDR.
// Words reach inst_valid one cycle after imem_rd_valid; reads are credit-limited so the output FIFO never overflows.
module inst_fetch_sequencer #(
    parameter int         INST_DATA_WIDTH = 32,
    parameter int         INST_ADDR_WIDTH = 10,
    parameter int         AXI_ADDR_WIDTH  = 42,
    parameter int         MEM_REQ_W       = 16,
    parameter int         FIFO_DEPTH      = 4,
    parameter logic [3:0] END_OPCODE      = 4'hF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [AXI_ADDR_WIDTH-1:0]  base_addr,
    input  logic [MEM_REQ_W-1:0]       block_bytes,
    input  logic [15:0]                num_blocks,
    input  logic                       imem_block_ready,
    output logic                       imem_rd_req,
    output logic [INST_ADDR_WIDTH-1:0] imem_rd_addr,
    input  logic [INST_DATA_WIDTH-1:0] imem_rd_data,
    input  logic                       imem_rd_valid,
    output logic                       imem_rd_block_done,
    output logic [AXI_ADDR_WIDTH-1:0]  decoder_ld_addr,
    output logic [MEM_REQ_W-1:0]       decoder_ld_req_size,
    output logic                       decoder_ld_req_in,
    output logic [INST_DATA_WIDTH-1:0] inst_data,
    output logic                       inst_valid,
    input  logic                       inst_ready,
    output logic                       busy,
    output logic                       done,
    output logic                       overrun_err
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [2:0] {S_IDLE, S_WAIT_BLK, S_FETCH, S_DRAIN, S_DONE} state_t;
    state_t state_q, state_d;

    logic [AXI_ADDR_WIDTH-1:0]  base_q, base_d, ld_addr_q, ld_addr_d, nxt_off;
    logic [MEM_REQ_W-1:0]       bytes_q, bytes_d, ld_size_q, ld_size_d;
    logic [15:0]                num_q, num_d, blk_cnt_q, blk_cnt_d;
    logic [INST_ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d, ret_addr_q, ret_addr_d;
    logic                       end_seen_q, end_seen_d, top_issued_q, top_issued_d;
    logic                       overrun_q, overrun_d, ld_tgl_q, ld_tgl_d;
    logic [CW-1:0]              outstanding_q, outstanding_d, count_q, count_d;
    logic [PW-1:0]              wr_ptr_q, rd_ptr_q;
    logic [INST_DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];

    logic        issue, push, pop, ret_is_end, drained;
    logic [CW:0] credit_used;
    logic [16:0] blk_nxt;

    assign blk_nxt     = {1'b0, blk_cnt_q} + 17'd1;
    assign nxt_off     = AXI_ADDR_WIDTH'(blk_nxt) * AXI_ADDR_WIDTH'(bytes_q);
    assign credit_used = (CW+1)'(count_q) + (CW+1)'(outstanding_q);
    // Buffered plus in-flight words never exceed the FIFO, so a returning word always has a slot.
    assign issue       = (state_q == S_FETCH) && !end_seen_q && !top_issued_q &&
                         (credit_used < (CW+1)'(FIFO_DEPTH));
    assign push        = imem_rd_valid && (state_q == S_FETCH) && !end_seen_q;
    assign pop         = (count_q != '0) && inst_ready;
    assign ret_is_end  = (imem_rd_data[INST_DATA_WIDTH-1 -: 4] == END_OPCODE) || (&ret_addr_q);
    assign drained     = (count_q == '0) && (outstanding_q == '0);

    always_comb begin
        state_d       = state_q;
        base_d        = base_q;
        bytes_d       = bytes_q;
        num_d         = num_q;
        blk_cnt_d     = blk_cnt_q;
        rd_addr_d     = rd_addr_q;
        ret_addr_d    = ret_addr_q;
        end_seen_d    = end_seen_q;
        top_issued_d  = top_issued_q;
        overrun_d     = overrun_q;
        ld_addr_d     = ld_addr_q;
        ld_size_d     = ld_size_q;
        ld_tgl_d      = ld_tgl_q;
        outstanding_d = outstanding_q;
        count_d       = count_q;

        if (issue)
            outstanding_d = outstanding_d + CW'(1);
        if (imem_rd_valid && (outstanding_q != '0))
            outstanding_d = outstanding_d - CW'(1);
        if (push && !pop)
            count_d = count_q + CW'(1);
        else if (!push && pop)
            count_d = count_q - CW'(1);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d    = base_addr;
                    bytes_d   = block_bytes;
                    num_d     = num_blocks;
                    blk_cnt_d = '0;
                    overrun_d = 1'b0;
                    state_d   = (num_blocks == 16'd0) ? S_DONE : S_WAIT_BLK;
                end
            end
            S_WAIT_BLK: begin
                if (imem_block_ready) begin
                    state_d      = S_FETCH;
                    rd_addr_d    = '0;
                    ret_addr_d   = '0;
                    end_seen_d   = 1'b0;
                    top_issued_d = 1'b0;
                    if (blk_nxt < {1'b0, num_q}) begin
                        ld_addr_d = base_q + nxt_off;
                        ld_size_d = bytes_q;
                        ld_tgl_d  = !ld_tgl_q;
                    end
                end
            end
            S_FETCH: begin
                if (issue) begin
                    rd_addr_d = rd_addr_q + INST_ADDR_WIDTH'(1);
                    // Top of imem reached without END: stop here rather than wrap.
                    if (&rd_addr_q) begin
                        top_issued_d = 1'b1;
                        overrun_d    = 1'b1;
                    end
                end
                if (push) begin
                    ret_addr_d = ret_addr_q + INST_ADDR_WIDTH'(1);
                    if (ret_is_end)
                        end_seen_d = 1'b1;
                end
                if (end_seen_q)
                    state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (drained) begin
                    blk_cnt_d = blk_cnt_q + 16'd1;
                    state_d   = (blk_nxt == {1'b0, num_q}) ? S_DONE : S_WAIT_BLK;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            base_q        <= '0;
            bytes_q       <= '0;
            num_q         <= '0;
            blk_cnt_q     <= '0;
            rd_addr_q     <= '0;
            ret_addr_q    <= '0;
            end_seen_q    <= 1'b0;
            top_issued_q  <= 1'b0;
            overrun_q     <= 1'b0;
            ld_addr_q     <= '0;
            ld_size_q     <= '0;
            ld_tgl_q      <= 1'b0;
            outstanding_q <= '0;
            count_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
        end else begin
            state_q       <= state_d;
            base_q        <= base_d;
            bytes_q       <= bytes_d;
            num_q         <= num_d;
            blk_cnt_q     <= blk_cnt_d;
            rd_addr_q     <= rd_addr_d;
            ret_addr_q    <= ret_addr_d;
            end_seen_q    <= end_seen_d;
            top_issued_q  <= top_issued_d;
            overrun_q     <= overrun_d;
            ld_addr_q     <= ld_addr_d;
            ld_size_q     <= ld_size_d;
            ld_tgl_q      <= ld_tgl_d;
            outstanding_q <= outstanding_d;
            count_q       <= count_d;
            if (push)
                wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)
                rd_ptr_q <= rd_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr_q] <= imem_rd_data;
    end

    assign imem_rd_req         = issue;
    assign imem_rd_addr        = rd_addr_q;
    assign imem_rd_block_done  = (state_q == S_DRAIN) && drained;
    assign decoder_ld_addr     = ld_addr_q;
    assign decoder_ld_req_size = ld_size_q;
    assign decoder_ld_req_in   = ld_tgl_q;
    assign inst_valid          = (count_q != '0);
    assign inst_data           = inst_valid ? fifo_mem[rd_ptr_q] : '0;
    assign busy                = (state_q == S_WAIT_BLK) || (state_q == S_FETCH) || (state_q == S_DRAIN);
    assign done                = (state_q == S_DONE);
    assign overrun_err         = overrun_q;
endmodule
